// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO: show-ahead pop, occupancy flags, sticky overrun.
// Define UART_RX_FIFO_IRQ_EN to add the registered level interrupt output irq.
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int IRQ_LEVEL = 1
) (
  input  logic              UART_CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
`ifdef UART_RX_FIFO_IRQ_EN
  input  logic              ovr_clr,
  output logic              irq
`else
  input  logic              ovr_clr
`endif
);

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

  // Elaboration guard on the geometry and the irq threshold.
  if (DEPTH != (1 << ADDR_W) || DEPTH < 2 ||
      IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_cfg
    $error("uart_rx_fifo: bad DEPTH/ADDR_W/IRQ_LEVEL");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovr;

  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_ovr_nxt;

  // A full FIFO still accepts a push when a pop frees the head slot.
  assign w_pop  = rd_en && (r_count != '0);
  assign w_push = rx_ready && ((r_count != LP_FULL) || w_pop);
  assign w_drop = rx_ready && (r_count == LP_FULL) && !w_pop;

  assign w_count_nxt = r_count
                     + (ADDR_W+1)'(w_push)
                     - (ADDR_W+1)'(w_pop);
  assign w_ovr_nxt   = w_drop || (r_ovr && !ovr_clr);

  always_ff @(posedge UART_CLK) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= rx_data;
  end

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [ADDR_W:0] LP_IRQ = (ADDR_W+1)'(IRQ_LEVEL);

  logic r_irq;

  always_ff @(posedge UART_CLK) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= (w_count_nxt >= LP_IRQ) || w_ovr_nxt;
  end

  assign irq = r_irq;
`endif

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign full    = (r_count == LP_FULL);
  assign count   = r_count;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// irq vectors run only when UART_RX_FIFO_IRQ_EN is defined.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;
`ifdef UART_RX_FIFO_IRQ_EN
  logic       irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(
    .DATA_W(8), .DEPTH(16), .ADDR_W(4), .IRQ_LEVEL(4)
  ) dut (
    .UART_CLK(clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
`ifdef UART_RX_FIFO_IRQ_EN
    .ovr_clr (ovr_clr),
    .irq     (irq)
`else
    .ovr_clr (ovr_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1ns after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    rx_data  = v;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] v);
    check(tag, 32'(rd_data), 32'(v));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    rx_data  = '0;
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    ovr_clr  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_count",   32'(count),   32'd0);
    check("rst_empty",   32'(empty),   32'd1);
    check("rst_full",    32'(full),    32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif

    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    check("idle_pop_count", 32'(count), 32'd0);
    check("idle_pop_empty", 32'(empty), 32'd1);

    push(8'h41);
    check("first_vis_data",  32'(rd_data), 32'h41);
    check("first_vis_empty", 32'(empty),   32'd0);
    push(8'h42);
    push(8'h43);
    check("abc_count", 32'(count), 32'd3);
    pop_chk("pop_a", 8'h41);
    pop_chk("pop_b", 8'h42);
    pop_chk("pop_c", 8'h43);
    check("abc_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovr",   32'(overrun), 32'd0);
    push(8'hAA);
    check("drop_ovr",   32'(overrun), 32'd1);
    check("drop_count", 32'(count),   32'd16);
    for (int i = 0; i < 16; i++) pop_chk("drain0", 8'(i));
    check("drain0_empty", 32'(empty),   32'd1);
    check("ovr_sticky",   32'(overrun), 32'd1);

    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);

    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    check("refill_count", 32'(count), 32'd16);
    rx_data  = 8'h55;
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    check("fullrw_head", 32'(rd_data), 32'h10);
    tick();
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    check("fullrw_count", 32'(count),   32'd16);
    check("fullrw_ovr",   32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk("drain1", 8'(8'h10 + i));
    pop_chk("wrap_55", 8'h55);
    check("drain1_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    push(8'h77);
    check("ovr2_set", 32'(overrun), 32'd1);
    rx_data  = 8'h78;
    rx_ready = 1'b1;
    ovr_clr  = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("set_wins",     32'(overrun), 32'd1);
    check("set_wins_cnt", 32'(count),   32'd16);
    tick();
    ovr_clr = 1'b0;
    check("clr_alone", 32'(overrun), 32'd0);

    pop_chk("after_ovr_pop", 8'h60);
    push(8'h99);
    check("space_push_cnt", 32'(count), 32'd16);
    for (int i = 1; i < 16; i++) pop_chk("drain2", 8'(8'h60 + i));
    pop_chk("drain2_99", 8'h99);
    check("drain2_empty", 32'(empty), 32'd1);

    rx_data  = 8'hC3;
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    tick();
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    check("emptyrw_count", 32'(count), 32'd1);
    pop_chk("emptyrw_data", 8'hC3);

    for (int i = 0; i < 4; i++) begin
      push(8'(8'hD0 + i));
`ifdef UART_RX_FIFO_IRQ_EN
      check("irq_fill", 32'(irq), (i == 3) ? 32'd1 : 32'd0);
`endif
    end
    pop_chk("irq_pop", 8'hD0);
    check("pre_rst_count", 32'(count), 32'd3);
`ifdef UART_RX_FIFO_IRQ_EN
    check("irq_low", 32'(irq), 32'd0);
`endif

    reset    = 1'b0;
    rx_data  = 8'hEE;
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    tick();
    reset    = 1'b1;
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    check("mid_rst_count", 32'(count),   32'd0);
    check("mid_rst_empty", 32'(empty),   32'd1);
    check("mid_rst_full",  32'(full),    32'd0);
    check("mid_rst_ovr",   32'(overrun), 32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
    check("mid_rst_irq", 32'(irq), 32'd0);
`endif
    push(8'h5A);
    check("post_rst_data", 32'(rd_data), 32'h5A);
    check("post_rst_cnt",  32'(count),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
